// File: rtl/hex_to_sseg_test.sv
// Seven-segment board demo: shows sw as two hex digits on the right and sw+1 on the left.
// The demo is built from a hex-to-segment decoder and a 4-digit time-multiplexed driver.

module hex_to_sseg (
  input  logic [3:0] hex,
  input  logic       dp,
  output logic [7:0] sseg
);
  // Segments are active low, a at bit 6 down to g at bit 0.
  always_comb begin
    sseg = '1;
    case (hex)
      4'h0: sseg[6:0] = 7'b0000001;
      4'h1: sseg[6:0] = 7'b1001111;
      4'h2: sseg[6:0] = 7'b0010010;
      4'h3: sseg[6:0] = 7'b0000110;
      4'h4: sseg[6:0] = 7'b1001100;
      4'h5: sseg[6:0] = 7'b0100100;
      4'h6: sseg[6:0] = 7'b0100000;
      4'h7: sseg[6:0] = 7'b0001111;
      4'h8: sseg[6:0] = 7'b0000000;
      4'h9: sseg[6:0] = 7'b0000100;
      4'ha: sseg[6:0] = 7'b0001000;
      4'hb: sseg[6:0] = 7'b1100000;
      4'hc: sseg[6:0] = 7'b0110001;
      4'hd: sseg[6:0] = 7'b1000010;
      4'he: sseg[6:0] = 7'b0110000;
      default: sseg[6:0] = 7'b0111000;
    endcase
    sseg[7] = dp;
  end
endmodule

module disp_mux #(
  parameter int N = 18
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] in0,
  input  logic [7:0] in1,
  input  logic [7:0] in2,
  input  logic [7:0] in3,
  output logic [3:0] an,
  output logic [7:0] sseg
);
  logic [N-1:0] q;
  logic [1:0]   sel;

  always_ff @(posedge clk) begin
    if (!rst_n) q <= '0;
    else        q <= q + 1'b1;
  end

  // The two counter MSBs pick the digit, so each one is held for 2^(N-2) clocks.
  assign sel = q[N-1:N-2];

  always_comb begin
    an   = 4'b1110;
    sseg = in0;
    case (sel)
      2'b00: begin an = 4'b1110; sseg = in0; end
      2'b01: begin an = 4'b1101; sseg = in1; end
      2'b10: begin an = 4'b1011; sseg = in2; end
      default: begin an = 4'b0111; sseg = in3; end
    endcase
  end
endmodule

module hex_to_sseg_test #(
  parameter int N = 18
) (
  input  logic       clk_amisha,
  input  logic       rst_n_amisha,
  input  logic [7:0] sw_amisha,
  output logic [3:0] an_amisha,
  output logic [7:0] sseg_amisha
);
  logic [7:0] inc;
  logic [7:0] led0, led1, led2, led3;

  assign inc = sw_amisha + 8'd1;

  hex_to_sseg u_dec0 (.hex(sw_amisha[3:0]), .dp(1'b1), .sseg(led0));
  hex_to_sseg u_dec1 (.hex(sw_amisha[7:4]), .dp(1'b1), .sseg(led1));
  hex_to_sseg u_dec2 (.hex(inc[3:0]),       .dp(1'b1), .sseg(led2));
  hex_to_sseg u_dec3 (.hex(inc[7:4]),       .dp(1'b1), .sseg(led3));

  disp_mux #(.N(N)) u_mux (
    .clk   (clk_amisha),
    .rst_n (rst_n_amisha),
    .in0   (led0),
    .in1   (led1),
    .in2   (led2),
    .in3   (led3),
    .an    (an_amisha),
    .sseg  (sseg_amisha)
  );
endmodule

// File: tb/tb_hex_to_sseg_test.sv
// Directed bench for the seven-segment demo with N=4 (each digit held 4 clocks).
// Expected patterns come from a hand-written segment table and a tracked counter.

module tb_hex_to_sseg_test;
  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] sw;
  logic [3:0] an;
  logic [7:0] sseg;

  int checks   = 0;
  int failures = 0;
  int unsigned qm = 0;

  logic [6:0] seg_tab [16];
  logic [3:0] an_tab  [4];

  hex_to_sseg_test #(.N(4)) dut (
    .clk_amisha   (clk),
    .rst_n_amisha (rst_n),
    .sw_amisha    (sw),
    .an_amisha    (an),
    .sseg_amisha  (sseg)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // One clock: inputs are driven and outputs sampled around the falling edge.
  task automatic step(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) begin
      @(posedge clk);
      if (!rst_n) qm = 0;
      else        qm = (qm + 1) % 16;
      @(negedge clk);
    end
  endtask

  function automatic logic [7:0] exp_sseg(input logic [7:0] v, input int unsigned q);
    logic [7:0] inc;
    logic [3:0] nib;
    inc = v + 8'd1;
    case (q / 4)
      0: nib = v[3:0];
      1: nib = v[7:4];
      2: nib = inc[3:0];
      default: nib = inc[7:4];
    endcase
    return {1'b1, seg_tab[nib]};
  endfunction

  initial begin
    logic [7:0] scan_exp [4];
    logic [7:0] v;

    seg_tab = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
                7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};
    an_tab  = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

    // Reset with sw=05, then two full scans.
    rst_n = 1'b0;
    sw    = 8'h05;
    @(negedge clk);
    step(2);
    check("reset_an",   {4'h0, an}, 8'h0e);
    check("reset_sseg", sseg, 8'b10100100);
    rst_n = 1'b1;
    scan_exp = '{8'b10100100, 8'b10000001, 8'b10100000, 8'b10000001};
    for (int k = 0; k < 32; k++) begin
      check("scan05_an",   {4'h0, an}, {4'h0, an_tab[(k / 4) % 4]});
      check("scan05_sseg", sseg, scan_exp[(k / 4) % 4]);
      step(1);
    end

    // sw=FF: increment wraps to 00.
    sw = 8'hff;
    scan_exp = '{8'b10111000, 8'b10111000, 8'b10000001, 8'b10000001};
    for (int d = 0; d < 4; d++) begin
      #1;
      check("ff_an",   {4'h0, an}, {4'h0, an_tab[d]});
      check("ff_sseg", sseg, scan_exp[d]);
      step(4);
    end

    // sw=3A: A, 3, b, 3.
    sw = 8'h3a;
    scan_exp = '{8'b10001000, 8'b10000110, 8'b11100000, 8'b10000110};
    for (int d = 0; d < 4; d++) begin
      #1;
      check("3a_an",   {4'h0, an}, {4'h0, an_tab[d]});
      check("3a_sseg", sseg, scan_exp[d]);
      step(4);
    end

    // Reset pulse while digit2 is active restarts the scan at digit0.
    step(8);
    check("mid_pre_an", {4'h0, an}, 8'h0b);
    rst_n = 1'b0;
    step(1);
    check("mid_rst_an",   {4'h0, an}, 8'h0e);
    check("mid_rst_sseg", sseg, 8'b10001000);
    rst_n = 1'b1;
    step(1);
    check("mid_q1_an", {4'h0, an}, 8'h0e);
    step(3);
    check("mid_q4_an", {4'h0, an}, 8'h0d);

    // Reset held: display stays on digit0 while every decoder code is shown.
    rst_n = 1'b0;
    step(1);
    for (int h = 0; h < 16; h++) begin
      sw = 8'(h);
      step(1);
      check("dec_an",   {4'h0, an}, 8'h0e);
      check("dec_sseg", sseg, {1'b1, seg_tab[h]});
    end
    rst_n = 1'b1;

    // Sweep sw, changing it twice within each cycle; sseg follows immediately.
    for (int unsigned i = 0; i < 256; i++) begin
      v  = 8'(i);
      sw = v;
      #1;
      check("sweep_an",   {4'h0, an}, {4'h0, an_tab[qm / 4]});
      check("sweep_sseg", sseg, exp_sseg(v, qm));
      sw = ~v;
      #1;
      check("sweep_inv_sseg", sseg, exp_sseg(~v, qm));
      check("sweep_onehot", 8'($countones(~an)), 8'd1);
      step(1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
